image_crop_streamer: RTL and testbench
======================================

Name: image_crop_streamer

Overview:
- Upstream stage of myproject. Consumes a full raster-order IN_ROWS x IN_COLS pixel stream from the camera/frame path.
- Forwards only the OUT_ROWS x OUT_COLS window at origin (crop_y1, crop_x1), as the AXI-stream feeding conv2d_input_V_data_0_V.
- Frame start/finish use the ap_start/ap_done/ap_idle/ap_ready control protocol, so it chains with myproject.

Parameters:
FP_TOTAL, 16, pixel word width
IN_ROWS, 100, input frame rows
IN_COLS, 160, input frame columns
OUT_ROWS, 48, crop rows
OUT_COLS, 48, crop columns

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  reset, asynchronous, active-low
ap_start  in  1  start one frame (sampled in IDLE only)
crop_y1  in  $clog2(IN_ROWS)  crop origin row, latched at start
crop_x1  in  $clog2(IN_COLS)  crop origin column, latched at start
s_tdata  in  FP_TOTAL  input pixel
s_tvalid  in  1  input pixel valid
s_tready  out  1  stage accepts input pixel
m_tdata  out  FP_TOTAL  cropped pixel, to conv2d_input_V_data_0_V_TDATA
m_tvalid  out  1  cropped pixel valid
m_tready  in  1  downstream ready
ap_done  out  1  one-cycle pulse, frame complete
ap_ready  out  1  one-cycle pulse, same cycle as ap_done
ap_idle  out  1  high in IDLE
cfg_clamped  out  1  sticky: latched origin was clamped

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE; counters and FIFO are cleared.
  - Outputs: s_tready=0, m_tvalid=0, m_tdata=0, ap_done=0, ap_ready=0, ap_idle=1, cfg_clamped=0.
  - A partial frame is abandoned; no state survives reset.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on ap_start=1.
  - Latch y1 = min(crop_y1, IN_ROWS-OUT_ROWS) and x1 = min(crop_x1, IN_COLS-OUT_COLS).
  - cfg_clamped is set if either value was reduced, otherwise cleared. It holds until the next start.
  - Reset row=0 and col=0.
- RUN:
  - s_tready = (fifo_count < 2), registered.
  - An input beat is accepted when s_tvalid & s_tready.
  - On each accepted beat, col increments. At IN_COLS-1, col wraps to 0 and row increments.
  - A beat is in-window if y1 <= row < y1+OUT_ROWS and x1 <= col < x1+OUT_COLS.
  - In-window beats are pushed to the output FIFO; all other beats are discarded (consumed, not forwarded).
  - RUN -> DONE when the beat at (IN_ROWS-1, IN_COLS-1) has been accepted and the FIFO is empty. The whole frame is always consumed, so the next frame stays aligned.
- DONE:
  - ap_done=1 and ap_ready=1 for exactly one cycle, then return to IDLE.
- ap_start outside IDLE is ignored. In IDLE and DONE, s_tready=0.
- Output FIFO:
  - Two-entry skid buffer; m_tdata and m_tvalid are driven from registers.
  - m_tvalid = (fifo_count != 0).
  - Pop on m_tvalid & m_tready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - m_tdata and m_tvalid must not change while m_tvalid=1 and m_tready=0 (AXI stability).
- Latency: an in-window beat accepted at cycle N is presented on m_tvalid at cycle N+1 when the FIFO was empty.
- Throughput: 1 beat/cycle when m_tready is held high.
- Beat counts: exactly OUT_ROWS*OUT_COLS output beats per frame (2304 at default parameters), in raster order. No loss, no duplication.
- Width rules:
  - Row and column counters use $clog2(IN_ROWS) and $clog2(IN_COLS) bits.
  - Window compares use counter width + 1 bit, so there is no overflow at the edges.

Decomposition:
- Package crop_pkg:
  - Default geometry constants.
  - Counter widths.
  - FSM state enum.
  - Pixel typedef of FP_TOTAL bits.
- One sub-module: axis_skid_buffer (2-entry, parameterised by data width).

Test Plan:
- Default origin (10,10), pixel = row*160+col, both handshakes always high:
  - 2304 output beats; first = 1610, last = 9177.
  - ap_done pulses once; cfg_clamped = 0.
- Origin (60,120):
  - Origin is clamped to (52,112); cfg_clamped = 1.
  - First output = 8432, last = 15999; 2304 beats.
- Random s_tvalid and m_tready (50%), compared beat-by-beat against the benchmark file:
  - All 2304 beats match, in order.
  - m_tdata stays stable during every stall.
- ap_start pulsed mid-RUN with a new origin:
  - The current frame is unaffected; exactly one ap_done.
  - The next start uses the new origin.
- ap_rst_n asserted after 500 output beats:
  - Outputs go to reset values immediately; ap_idle = 1.
  - After restart, a full correct 2304-beat frame is produced.
- Two back-to-back frames (start issued the cycle after ap_done):
  - Both crops are correct; no s_tready in the gap cycle.

Source files
------------

// File: rtl/crop_pkg.sv
// crop_pkg: shared definitions for the image crop streamer.
//   - default frame / crop geometry and pixel width
//   - row / column counter widths for the default geometry
//   - FSM state encoding and pixel word type
package crop_pkg;

   localparam int unsigned FP_TOTAL_DEF = 16;
   localparam int unsigned IN_ROWS_DEF  = 100;
   localparam int unsigned IN_COLS_DEF  = 160;
   localparam int unsigned OUT_ROWS_DEF = 48;
   localparam int unsigned OUT_COLS_DEF = 48;

   localparam int unsigned ROW_W = $clog2(IN_ROWS_DEF);
   localparam int unsigned COL_W = $clog2(IN_COLS_DEF);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_t;

   typedef logic [FP_TOTAL_DEF-1:0] pixel_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: two-entry AXI-stream output FIFO with registered outputs.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_data, in_valid push side; caller only pushes while count_next of the
//                     previous cycle left room (count < 2)
//   out_data          head entry (register), held stable while stalled
//   out_valid         head entry present
//   out_ready         downstream ready; pop on out_valid & out_ready
//   count, count_next current occupancy and occupancy after this cycle
module axis_skid_buffer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       count,
   output logic [1:0]       count_next
);

   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] tail_q;
   logic [1:0]       count_q;
   logic             pop;

   assign pop       = out_valid & out_ready;
   assign out_valid = (count_q != 2'd0);
   assign out_data  = head_q;
   assign count     = count_q;

   always_comb begin
      count_next = count_q;
      case ({in_valid, pop})
         2'b10:   count_next = count_q + 2'd1;
         2'b01:   count_next = count_q - 2'd1;
         default: count_next = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         case ({in_valid, pop})
            2'b10: begin
               if (count_q == 2'd0) head_q <= in_data;
               else                 tail_q <= in_data;
            end
            2'b01: head_q <= tail_q;
            2'b11: begin
               // Full: tail advances to head, new beat lands behind it.
               if (count_q == 2'd2) begin
                  head_q <= tail_q;
                  tail_q <= in_data;
               end else begin
                  head_q <= in_data;
               end
            end
            default: ;
         endcase
         count_q <= count_next;
      end
   end

endmodule

// File: rtl/image_crop_streamer.sv
// image_crop_streamer: consumes a raster IN_ROWS x IN_COLS pixel stream and
// forwards only the OUT_ROWS x OUT_COLS window at the latched origin.
// Ports:
//   ap_clk, ap_rst_n            clock, asynchronous active-low reset
//   ap_start                    start one frame (honoured in IDLE only)
//   crop_y1, crop_x1            window origin, clamped and latched at start
//   s_tdata/s_tvalid/s_tready   input pixel stream
//   m_tdata/m_tvalid/m_tready   cropped pixel stream
//   ap_done, ap_ready           one-cycle pulse when the frame is complete
//   ap_idle                     high in IDLE
//   cfg_clamped                 latched origin was reduced to fit the frame
module image_crop_streamer
   import crop_pkg::*;
#(
   parameter int unsigned FP_TOTAL = FP_TOTAL_DEF,
   parameter int unsigned IN_ROWS  = IN_ROWS_DEF,
   parameter int unsigned IN_COLS  = IN_COLS_DEF,
   parameter int unsigned OUT_ROWS = OUT_ROWS_DEF,
   parameter int unsigned OUT_COLS = OUT_COLS_DEF
) (
   input  logic                       ap_clk,
   input  logic                       ap_rst_n,
   input  logic                       ap_start,
   input  logic [$clog2(IN_ROWS)-1:0] crop_y1,
   input  logic [$clog2(IN_COLS)-1:0] crop_x1,
   input  logic [FP_TOTAL-1:0]        s_tdata,
   input  logic                       s_tvalid,
   output logic                       s_tready,
   output logic [FP_TOTAL-1:0]        m_tdata,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   output logic                       ap_done,
   output logic                       ap_ready,
   output logic                       ap_idle,
   output logic                       cfg_clamped
);

   localparam int unsigned RW    = $clog2(IN_ROWS);
   localparam int unsigned CW    = $clog2(IN_COLS);
   localparam int unsigned YMAXI = IN_ROWS - OUT_ROWS;
   localparam int unsigned XMAXI = IN_COLS - OUT_COLS;
   localparam int unsigned RLAST = IN_ROWS - 1;
   localparam int unsigned CLAST = IN_COLS - 1;

   localparam logic [RW-1:0] Y_MAX    = YMAXI[RW-1:0];
   localparam logic [CW-1:0] X_MAX    = XMAXI[CW-1:0];
   localparam logic [RW-1:0] ROW_LAST = RLAST[RW-1:0];
   localparam logic [CW-1:0] COL_LAST = CLAST[CW-1:0];
   localparam logic [RW:0]   OUT_R_X  = OUT_ROWS[RW:0];
   localparam logic [CW:0]   OUT_C_X  = OUT_COLS[CW:0];

   state_t        state_q;
   logic [RW-1:0] row_q, y1_q;
   logic [CW-1:0] col_q, x1_q;
   logic          last_seen_q;
   logic          s_tready_q, ap_done_q, ap_ready_q, ap_idle_q, cfg_clamped_q;

   logic          accept, at_last, in_win, push;
   logic [RW:0]   row_x, y_lo, y_hi;
   logic [CW:0]   col_x, x_lo, x_hi;
   logic [1:0]    fifo_count, fifo_count_next;

   // Compare one bit wider than the counters so origin + size cannot wrap.
   assign row_x = {1'b0, row_q};
   assign y_lo  = {1'b0, y1_q};
   assign y_hi  = y_lo + OUT_R_X;
   assign col_x = {1'b0, col_q};
   assign x_lo  = {1'b0, x1_q};
   assign x_hi  = x_lo + OUT_C_X;

   assign in_win  = (row_x >= y_lo) && (row_x < y_hi) && (col_x >= x_lo) && (col_x < x_hi);
   assign accept  = s_tvalid & s_tready_q;
   assign at_last = (row_q == ROW_LAST) && (col_q == COL_LAST);
   assign push    = accept & in_win;

   axis_skid_buffer #(
      .WIDTH (FP_TOTAL)
   ) u_fifo (
      .clk        (ap_clk),
      .rst_n      (ap_rst_n),
      .in_data    (s_tdata),
      .in_valid   (push),
      .out_data   (m_tdata),
      .out_valid  (m_tvalid),
      .out_ready  (m_tready),
      .count      (fifo_count),
      .count_next (fifo_count_next)
   );

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q       <= StIdle;
         row_q         <= '0;
         col_q         <= '0;
         y1_q          <= '0;
         x1_q          <= '0;
         last_seen_q   <= 1'b0;
         s_tready_q    <= 1'b0;
         ap_done_q     <= 1'b0;
         ap_ready_q    <= 1'b0;
         ap_idle_q     <= 1'b1;
         cfg_clamped_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (ap_start) begin
                  y1_q          <= (crop_y1 > Y_MAX) ? Y_MAX : crop_y1;
                  x1_q          <= (crop_x1 > X_MAX) ? X_MAX : crop_x1;
                  cfg_clamped_q <= (crop_y1 > Y_MAX) || (crop_x1 > X_MAX);
                  row_q         <= '0;
                  col_q         <= '0;
                  last_seen_q   <= 1'b0;
                  s_tready_q    <= 1'b1;
                  ap_idle_q     <= 1'b0;
                  state_q       <= StRun;
               end
            end
            StRun: begin
               if (accept) begin
                  if (col_q == COL_LAST) begin
                     col_q <= '0;
                     row_q <= row_q + RW'(1);
                  end else begin
                     col_q <= col_q + CW'(1);
                  end
                  if (at_last) last_seen_q <= 1'b1;
               end
               if (last_seen_q && (fifo_count == 2'd0)) begin
                  s_tready_q <= 1'b0;
                  ap_done_q  <= 1'b1;
                  ap_ready_q <= 1'b1;
                  state_q    <= StDone;
               end else begin
                  // Stop taking input once the frame's last beat is in, so the
                  // next frame stays aligned; otherwise keep one slot free.
                  s_tready_q <= !(last_seen_q || (accept && at_last)) &&
                                (fifo_count_next < 2'd2);
               end
            end
            StDone: begin
               ap_done_q  <= 1'b0;
               ap_ready_q <= 1'b0;
               ap_idle_q  <= 1'b1;
               state_q    <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign s_tready    = s_tready_q;
   assign ap_done     = ap_done_q;
   assign ap_ready    = ap_ready_q;
   assign ap_idle     = ap_idle_q;
   assign cfg_clamped = cfg_clamped_q;

endmodule

// File: tb/tb_image_crop_streamer.sv
// tb_image_crop_streamer: directed frames through image_crop_streamer with
// pixel value = row*160+col (i.e. the raster index), so every expected output
// beat is computed directly from the expected window origin.
module tb_image_crop_streamer;
   import crop_pkg::*;

   logic             ap_clk = 1'b0;
   logic             ap_rst_n;
   logic             ap_start;
   logic [ROW_W-1:0] crop_y1;
   logic [COL_W-1:0] crop_x1;
   pixel_t           s_tdata;
   logic             s_tvalid;
   logic             s_tready;
   pixel_t           m_tdata;
   logic             m_tvalid;
   logic             m_tready;
   logic             ap_done;
   logic             ap_ready;
   logic             ap_idle;
   logic             cfg_clamped;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 ap_clk = ~ap_clk;

   image_crop_streamer dut (
      .ap_clk      (ap_clk),
      .ap_rst_n    (ap_rst_n),
      .ap_start    (ap_start),
      .crop_y1     (crop_y1),
      .crop_x1     (crop_x1),
      .s_tdata     (s_tdata),
      .s_tvalid    (s_tvalid),
      .s_tready    (s_tready),
      .m_tdata     (m_tdata),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .ap_done     (ap_done),
      .ap_ready    (ap_ready),
      .ap_idle     (ap_idle),
      .cfg_clamped (cfg_clamped)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Must be entered at a negedge with the DUT in IDLE; returns at the negedge
   // of the following IDLE cycle so the next frame can start back-to-back.
   task automatic run_frame(input int oy, input int ox, input int ey, input int ex,
                            input bit rnd, input bit exp_clamp, input int rst_after,
                            input int mid_start_at);
      int     in_idx  = 0;
      int     out_idx = 0;
      bit     stall   = 1'b0;
      bit     done_seen = 1'b0;
      pixel_t held    = '0;
      int     e;
      check_eq("idle_before_start", 32'(ap_idle), 32'd1);
      check_eq("tready_in_idle", 32'(s_tready), 32'd0);
      crop_y1  = oy[ROW_W-1:0];
      crop_x1  = ox[COL_W-1:0];
      ap_start = 1'b1;
      for (int cyc = 0; cyc < 40000; cyc++) begin
         @(negedge ap_clk);
         ap_start = (cyc == mid_start_at);
         if (cyc == mid_start_at) begin
            crop_y1 = 7'd5;
            crop_x1 = 8'd7;
         end
         if (cyc == 0) begin
            check_eq("cfg_clamped", 32'(cfg_clamped), 32'(exp_clamp));
            check_eq("idle_in_run", 32'(ap_idle), 32'd0);
         end
         if (stall) begin
            check_eq("stall_valid", 32'(m_tvalid), 32'd1);
            check_eq("stall_data", 32'(m_tdata), 32'(held));
         end
         if (ap_done) begin
            check_eq("ready_with_done", 32'(ap_ready), 32'd1);
            check_eq("beat_count", 32'(out_idx), 32'd2304);
            check_eq("inputs_consumed", 32'(in_idx), 32'd16000);
            done_seen = 1'b1;
            break;
         end
         if (rst_after > 0 && out_idx == rst_after) begin
            ap_rst_n = 1'b0;
            s_tvalid = 1'b0;
            m_tready = 1'b0;
            #1;
            check_eq("rst_s_tready", 32'(s_tready), 32'd0);
            check_eq("rst_m_tvalid", 32'(m_tvalid), 32'd0);
            check_eq("rst_m_tdata", 32'(m_tdata), 32'd0);
            check_eq("rst_ap_idle", 32'(ap_idle), 32'd1);
            check_eq("rst_ap_done", 32'(ap_done), 32'd0);
            check_eq("rst_cfg_clamped", 32'(cfg_clamped), 32'd0);
            @(negedge ap_clk);
            ap_rst_n = 1'b1;
            return;
         end
         s_tvalid = (in_idx < 16000) && (!rnd || ($urandom_range(1, 0) == 1));
         s_tdata  = in_idx[FP_TOTAL_DEF-1:0];
         m_tready = !rnd || ($urandom_range(1, 0) == 1);
         if (m_tvalid && m_tready) begin
            e = (ey + out_idx / 48) * 160 + ex + out_idx % 48;
            if (out_idx < 2304) check_eq("beat", 32'(m_tdata), e);
            else                check_eq("extra_beat", 32'(out_idx), 32'd2303);
            out_idx++;
         end
         stall = m_tvalid && !m_tready;
         held  = m_tdata;
         if (s_tvalid && s_tready) in_idx++;
      end
      if (!done_seen) check_eq("frame_timeout", 32'd1, 32'd0);
      s_tvalid = 1'b0;
      @(negedge ap_clk);
      check_eq("done_one_cycle", 32'(ap_done), 32'd0);
      check_eq("idle_after_done", 32'(ap_idle), 32'd1);
      check_eq("tready_gap", 32'(s_tready), 32'd0);
   endtask

   initial begin
      ap_rst_n = 1'b0;
      ap_start = 1'b0;
      crop_y1  = '0;
      crop_x1  = '0;
      s_tdata  = '0;
      s_tvalid = 1'b0;
      m_tready = 1'b0;
      repeat (3) @(negedge ap_clk);
      check_eq("reset_idle", 32'(ap_idle), 32'd1);
      check_eq("reset_s_tready", 32'(s_tready), 32'd0);
      check_eq("reset_m_tvalid", 32'(m_tvalid), 32'd0);
      check_eq("reset_m_tdata", 32'(m_tdata), 32'd0);
      check_eq("reset_ap_done", 32'(ap_done), 32'd0);
      check_eq("reset_ap_ready", 32'(ap_ready), 32'd0);
      check_eq("reset_cfg_clamped", 32'(cfg_clamped), 32'd0);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);

      // Default origin, both handshakes high: first 1610, last 9177.
      run_frame(10, 10, 10, 10, 1'b0, 1'b0, 0, -1);
      // Clamped origin, random handshakes, start pulsed mid-frame with (5,7).
      run_frame(60, 120, 52, 112, 1'b1, 1'b1, 0, 3000);
      // Back-to-back start with the new origin: first 807.
      run_frame(5, 7, 5, 7, 1'b0, 1'b0, 0, -1);
      // Largest unclamped origin, reset after 500 output beats.
      run_frame(52, 112, 52, 112, 1'b0, 1'b0, 500, -1);
      // Full frame after reset at origin (0,0).
      run_frame(0, 0, 0, 0, 1'b0, 1'b0, 0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
